// File: rtl/aes_round_seq_pkg.sv
// aes_round_seq_pkg: shared types and constants for the byte-serial AES round sequencer
package aes_round_seq_pkg;
  typedef enum logic [0:0] {ASIC, FPGA} environment_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} aes_seq_state_e;
  localparam int AES_SEQ_STEPS = 16;
endpackage

// File: rtl/aes_round_seq.sv
// aes_round_seq: one AES round as 16 (column, byte) steps through an external aes32esmi unit; req_*/resp_* valid-ready handshake, flush abort, aes_* drive the unit whose result returns on aes_rd
module aes_round_seq
  import aes_round_seq_pkg::*;
#(
  parameter environment_e ENVIRONMENT = ASIC,
  parameter bit LOGIC_GATING = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_state,
  input  logic [127:0] req_rkey,
  input  logic         req_mix,
  input  logic         flush,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_state,
  output logic [31:0]  aes_rs1,
  output logic [31:0]  aes_rs2,
  output logic [1:0]   aes_bs,
  output logic         aes_mix,
  output logic         aes_valid,
  input  logic [31:0]  aes_rd
);
  aes_seq_state_e state_q, state_d;
  logic [3:0] step_q;
  logic [127:0] st_q, rk_q, res_q;
  logic [31:0] acc_q;
  logic mix_q, run, accept, last, gate;
  logic [1:0] col, bs, src;
  assign col = step_q[3:2];
  assign bs = step_q[1:0];
  assign src = col + bs;
  assign run = state_q == RUN;
  assign accept = req_valid && req_ready && !flush;
  assign last = run && step_q == 4'(AES_SEQ_STEPS - 1);
  assign gate = run || !LOGIC_GATING;
  assign resp_state = res_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = flush ? IDLE : accept ? RUN : last ? DONE : (state_q == DONE && resp_ready) ? IDLE : state_q;
    req_ready = state_q == IDLE;
    resp_valid = state_q == DONE;
    aes_valid = run;
    aes_mix = mix_q;
    aes_bs = gate ? bs : 2'd0;
    aes_rs2 = gate ? st_q[32*src +: 32] : 32'd0;
    aes_rs1 = gate ? (bs == 2'd0 ? rk_q[32*col +: 32] : acc_q) : 32'd0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      step_q <= '0;
      st_q <= '0;
      rk_q <= '0;
      mix_q <= 1'b0;
      acc_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      step_q <= '0;
    end else if (accept) begin
      st_q <= req_state;
      rk_q <= req_rkey;
      mix_q <= req_mix;
      step_q <= '0;
    end else if (run) begin
      acc_q <= aes_rd;
      step_q <= step_q + 4'd1;
      if (bs == 2'd3) res_q[32*col +: 32] <= aes_rd;
    end
endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: directed AES round vectors against a behavioural aes32esmi unit, scoreboard-checked
module tb_aes_round_seq;
  import aes_round_seq_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_mix = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [127:0] req_state = '0, req_rkey = '0;
  logic req_ready, resp_valid, aes_mix, aes_valid;
  logic [127:0] resp_state;
  logic [31:0] aes_rs1, aes_rs2, aes_rd;
  logic [1:0] aes_bs;
  int checks = 0, failures = 0;
  logic [127:0] exp_q[$];
  localparam logic [127:0] FIPS_ST = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] FIPS_RK = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
  localparam logic [127:0] FIPS_EX = 128'h49506a02_43ea5b6b_2b359f68_f27f9ca4;
  localparam logic [127:0] C63 = {16{8'h63}};
  localparam logic [127:0] KEY_X = 128'hffffffff_00000000_ffffffff_00000000;
  localparam logic [127:0] EXP_X = 128'h9c9c9c9c_63636363_9c9c9c9c_63636363;
  always #5 clk = ~clk;
  aes_round_seq #(.ENVIRONMENT(ASIC), .LOGIC_GATING(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_rkey(req_rkey), .req_mix(req_mix), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_state(resp_state),
    .aes_rs1(aes_rs1), .aes_rs2(aes_rs2), .aes_bs(aes_bs), .aes_mix(aes_mix),
    .aes_valid(aes_valid), .aes_rd(aes_rd)
  );
  function automatic logic [7:0] gm2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = gm2(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] aes_unit(input logic [31:0] rs1, input logic [31:0] rs2, input logic [1:0] bs, input logic mix);
    logic [4:0] sh;
    logic [7:0] so;
    logic [31:0] m, t;
    logic [63:0] d;
    sh = {bs, 3'b000};
    t = rs2 >> sh;
    so = sbox(t[7:0]);
    m = mix ? {gm2(so) ^ so, so, so, gm2(so)} : {24'h0, so};
    d = {m, m} << sh;
    return rs1 ^ d[63:32];
  endfunction
  always_comb aes_rd = aes_unit(aes_rs1, aes_rs2, aes_bs, aes_mix);
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected response", resp_state, '0);
      else chk("resp_state", resp_state, exp_q.pop_front());
    end
  end
  task automatic chk_reset_vals();
    chk("rst req_ready", req_ready, 1);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_state", resp_state, 0);
    chk("rst aes_valid", aes_valid, 0);
    chk("rst aes_if", {aes_rs1, aes_rs2, aes_bs, aes_mix}, 0);
  endtask
  task automatic send(input logic [127:0] st, input logic [127:0] rk, input logic mix);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("req_ready timeout", req_ready, 1);
    req_state = st;
    req_rkey = rk;
    req_mix = mix;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic run_req(input logic [127:0] st, input logic [127:0] rk, input logic mix, input logic [127:0] exp, input int hold);
    int n;
    exp_q.push_back(exp);
    send(st, rk, mix);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 16);
    repeat (hold) begin
      @(negedge clk);
      chk("bp resp_valid", resp_valid, 1);
      chk("bp resp_state", resp_state, exp);
      chk("bp req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    chk("req_ready while taking", req_ready, 0);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("req_ready after take", req_ready, 1);
    chk("resp_valid after take", resp_valid, 0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    @(negedge clk);
    run_req(FIPS_ST, FIPS_RK, 1'b1, FIPS_EX, 0);
    run_req('0, '0, 1'b0, C63, 10);
    run_req('0, '0, 1'b1, C63, 0);
    run_req('0, KEY_X, 1'b0, EXP_X, 0);
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush beats accept aes_valid", aes_valid, 0);
    chk("flush beats accept req_ready", req_ready, 1);
    send(FIPS_ST, FIPS_RK, 1'b1);
    repeat (7) @(negedge clk);
    chk("running before flush", aes_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush req_ready", req_ready, 1);
    chk("flush aes_valid", aes_valid, 0);
    seen = 0;
    repeat (20) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("no resp after flush", seen, 0);
    run_req(FIPS_ST, FIPS_RK, 1'b1, FIPS_EX, 0);
    send(FIPS_ST, FIPS_RK, 1'b1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_req('0, '0, 1'b0, C63, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
Multi-cycle sequencer that computes one full forward AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) on a 128-bit state. It reuses a single external byte-wise AES unit, the one that implements aes32esmi/aes32esi. Each cycle it drives one (column, byte-select) step into the unit. It sits beside the execute stage as an accelerator datapath and exposes a valid/ready request/response handshake.

Parameters:
- Environment, ASIC: environment_e value. Informational only; the sequencer's behaviour does not depend on it.
- LOGIC_GATING, 0: when 1, force aes_rs1/aes_rs2/aes_bs to 0 whenever aes_valid=0, to save toggling.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_state  in  128  input state; column c = req_state[32c+31:32c], byte 0 = row 0 (little-endian word)
- req_rkey  in  128  round key; same column packing as req_state
- req_mix  in  1  1 = middle round (MixColumns), 0 = final round
- flush  in  1  synchronous abort
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_state  out  128  round output; same column packing
- aes_rs1  out  32  to AES unit rs1 (accumulator)
- aes_rs2  out  32  to AES unit rs2 (source column)
- aes_bs  out  2  to AES unit byte select
- aes_mix  out  1  to AES unit mix select
- aes_valid  out  1  to AES unit valid
- aes_rd  in  32  from AES unit; combinational result

Behaviour:
- Reset values:
  - req_ready=1; resp_valid=0; resp_state=0; aes_valid=0.
  - aes_rs1/aes_rs2/aes_bs/aes_mix=0.
  - All internal registers (state, rkey, mix, acc, counters, result) cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_state, req_rkey and req_mix, set col=0 and bs=0, go to RUN.
- RUN:
  - req_ready=0; aes_valid=1; aes_mix = latched mix; aes_bs = bs.
  - aes_rs2 = state column (col+bs) mod 4. This realises ShiftRows.
  - aes_rs1 = rkey column col when bs==0, otherwise acc.
  - Each cycle: acc <= aes_rd. When bs==3, result[col] <= aes_rd.
  - bs increments mod 4. col increments when bs wraps from 3 to 0.
  - Step (col=3, bs=3) goes to DONE.
  - Exactly 16 RUN cycles.
- DONE:
  - resp_valid=1; resp_state = result, held stable.
  - On resp_ready, go to IDLE.
  - A new request is not accepted in the same cycle the response is taken; req_ready rises the following cycle.
- Latency: request accepted at clock edge k gives resp_valid=1 after edge k+16. Throughput is one round per 18 cycles without backpressure.
- Backpressure: resp_valid, resp_state and the FSM hold indefinitely while resp_ready=0.
- flush:
  - In any state, on the next edge go to IDLE, clear counters and drop resp_valid. resp_state is left stale.
  - flush has priority over acceptance: a req_valid coinciding with flush is not accepted.
- Reset asserted mid-RUN or mid-DONE: immediately return to reset values; the partial result is discarded.
- Width rules: all XOR accumulation is 32-bit with no carries. Counters are 2 bits and wrap.
- aes_rd is used only in RUN. Its value in other states is ignored.

Decomposition:
- RS5_pkg gains:
  - typedef aes_seq_state_e {IDLE, RUN, DONE}.
  - Localparam AES_SEQ_STEPS = 16.
- No sub-module inside the sequencer. The existing AES unit is instantiated by the parent; the testbench instantiates it alongside.

Test Plan:
- FIPS-197 round 1, mix=1:
  - Stimulus: state cols {0xbee33d19, 0x2be2f4a0, 0x2a8dc69a, 0x0848f8e9}, rkey col0 0x17fefaa0, rest of rkey per FIPS key schedule.
  - Required: resp col0=0xf27f9ca4, col1=0x2b359f68, resp_valid exactly 16 cycles after acceptance.
- All-zero state/rkey, mix=0 -> resp_state=0x63636363_63636363_63636363_63636363.
- All-zero state/rkey, mix=1 -> same 0x63… value in every byte (MixColumns of a constant column is identity).
- Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid and resp_state stable, req_ready=0. After resp_ready pulse -> req_ready=1 next cycle.
- flush at RUN step 7 -> IDLE next cycle, no resp_valid. A following request completes with the correct result.
- reset_n low at RUN step 5, release, then issue the zero-vector request -> 0x63… result; all outputs at reset values during reset.
